bmw_op_scheduler: RTL and testbench
===================================

// Module: bmw_op_scheduler
// PURPOSE
//  Front-end controller for one BMW PIFO tree: accepts client push/pop requests, buffers pushes in a small FIFO,
//  tracks tree occupancy, and sequences single operations into the push RPU and pop RPU sharing the tree SRAM.
//  Sits between the client (traffic manager / virtualization layer) and the push/pop RPU pair.
// PARAMETERS
//  PTW   16                     payload width; all-ones payload = empty sentinel
//  MTW   0                      metadata width
//  LEVEL 8                      tree levels, 4-ary, 4 entries per node
//  CAP   (4**(LEVEL+1)-4)/3     tree capacity in entries
//  QD    4                      push FIFO depth, power of 2, >=2
//  GAP   1                      idle cycles enforced between a push issue and the next pop issue (root write in flight)
// PORTS
//  i_clk             in   1          clock
//  i_arst_n          in   1          async active-low reset
//  i_push_valid      in   1          client push request
//  i_push_data       in   MTW+PTW    client push element
//  o_push_ready      out  1          FIFO can accept; transfer on valid&ready
//  i_pop_valid       in   1          client pop request
//  o_pop_ready       out  1          pop request accepted on valid&ready
//  o_rsp_valid       out  1          1-cycle pulse, pop response
//  o_rsp_data        out  MTW+PTW    popped element; all-ones when empty
//  o_rsp_empty       out  1          qualifies o_rsp_valid: tree and FIFO were empty
//  o_rpu_push        out  1          push command to push RPU
//  o_rpu_push_data   out  MTW+PTW    push element to push RPU
//  i_rpu_push_ready  in   1          push RPU ready
//  o_rpu_pop         out  1          pop command to pop RPU
//  i_rpu_pop_ready   in   1          pop RPU ready
//  i_rpu_pop_valid   in   1          pop RPU result valid
//  i_rpu_pop_data    in   MTW+PTW    pop RPU result
//  o_count           out  $clog2(CAP+1)  entries in tree (issued pushes - issued pops)
//  o_full            out  1          o_count==CAP
// BEHAVIOUR
//  Reset: all outputs 0 except o_rsp_data='1, o_push_ready=1; FIFO empty, count=0, FSM=ST_IDLE, rr=0, gap=0.
//  Reset mid-op drops FIFO and outstanding pop; no response issued.
//  Push FIFO: write on i_push_valid&o_push_ready; o_push_ready=~fifo_full (no bypass when full).
//   Head visible for issue the cycle after write (1-cycle min push latency).
//  FSM ST_IDLE: push eligible = fifo_nonempty & ~o_full & i_rpu_push_ready.
//   Pop eligible = i_pop_valid & i_rpu_pop_ready & gap==0 & count>0.
//   Both eligible: round-robin, grant side opposite last grant (rr); rr updates on each grant.
//   i_pop_valid with count==0 & fifo_nonempty: push forced (pop waits).
//   i_pop_valid with count==0 & fifo empty: o_pop_ready=1, next cycle o_rsp_valid=1, o_rsp_empty=1, data='1; stay IDLE.
//   Push grant: o_rpu_push=1 one cycle with FIFO head, pop FIFO, count+1, gap<=GAP.
//   Pop grant: o_rpu_pop=1 and o_pop_ready=1 one cycle, count-1, -> ST_POP.
//  ST_POP: no issue of either op; on i_rpu_pop_valid: o_rsp_valid=1 next cycle, data=i_rpu_pop_data,
//   o_rsp_empty=0 -> ST_IDLE. Pushes still enqueue into FIFO.
//  gap decrements to 0 each cycle; at most one RPU command per cycle; o_pop_ready only 1 on grant/empty reply.
//  o_full: push held at FIFO head (not dropped) until a pop frees space.
//  count never wraps: issue logic guarantees 0<=count<=CAP; assertions flag violation.
// CONFIGURATION
//  BMW_SCHED_STATS_EN defined: extra ports i_stat_clr(in,1), o_stat_push(out,32), o_stat_pop(out,32),
//   o_stat_empty_pop(out,32): count push issues, pop issues, empty replies; wrap at 2^32; sync clear, clear wins.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  bmw_pkg: sched_state_t {ST_IDLE, ST_POP}; EMPTY_ELEM all-ones constant; bmw_cap(LEVEL) function.
//  Sub-module bmw_sched_fifo (sync FIFO, QD x MTW+PTW, full/empty flags); arbitration + FSM + counters in top.
// TESTING
//  T1 reset, pop with empty tree/FIFO -> o_pop_ready=1, next cycle o_rsp_valid=1, o_rsp_empty=1, o_rsp_data=16'hFFFF.
//  T2 push 5,3,9 back-to-back -> three o_rpu_push pulses, data 5,3,9 in order, o_count=3.
//  T3 push 7 then pop same cycle as push issue -> pop issued >=GAP+1 cycles after push; response 7, o_count=0.
//  T4 continuous push+pop pending, count>0 -> grants alternate push/pop/push; no cycle with both commands.
//  T5 CAP=4, push 6 -> 4 issued, o_full=1, 2 held in FIFO; one pop -> one held push issues after response.
//  T6 assert reset during ST_POP -> no o_rsp_valid, count=0, FIFO empty, o_push_ready=1 after release.

Source files
------------

// File: rtl/bmw_pkg.sv
// Shared types and constants for the BMW PIFO front-end scheduler.
// Holds the FSM state type, the empty-element sentinel and the tree capacity helper.
package bmw_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_POP  = 1'b1
  } sched_state_t;

  // Wide enough for any supported element width; users slice the low bits.
  localparam logic [63:0] EMPTY_ELEM = '1;

  // Entries in a 4-ary tree of 'level' levels with 4 entries per node.
  function automatic int bmw_cap(input int level);
    return (32'sd4 ** (level + 32'sd1) - 32'sd4) / 32'sd3;
  endfunction

endpackage

// File: rtl/bmw_sched_chk.sv
// Run-time invariant checks for the scheduler: occupancy bounds and one RPU command per cycle.
module bmw_sched_chk #(
  parameter int CW  = 3,
  parameter int CAP = 4
) (
  input logic          i_clk,
  input logic          i_arst_n,
  input logic [CW-1:0] i_count,
  input logic          i_rpu_push,
  input logic          i_rpu_pop
);

  a_count_le_cap: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    i_count <= CW'(CAP));

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    !(i_rpu_push && (i_count == CW'(CAP))));

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    !(i_rpu_pop && (i_count == '0)));

  a_one_cmd: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    !(i_rpu_push && i_rpu_pop));

endmodule

// File: rtl/bmw_sched_fifo.sv
// Synchronous FIFO that buffers client pushes until the scheduler issues them.
// The head entry is readable the cycle after it is written.
module bmw_sched_fifo #(
  parameter int W  = 16,
  parameter int QD = 4
) (
  input  logic         i_clk,
  input  logic         i_arst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(QD);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [QD];
  logic         wr_en_s;
  logic         rd_en_s;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next state.
  always_comb begin
    wr_en_s  = i_wr & ~o_full;
    rd_en_s  = i_rd & ~o_empty;
    wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/bmw_op_scheduler.sv
// Front-end scheduler for one BMW PIFO tree: buffers pushes, tracks occupancy, issues one RPU op per cycle.
// Optional BMW_SCHED_STATS_EN adds push/pop/empty-reply statistics counters with a synchronous clear.
module bmw_op_scheduler
  import bmw_pkg::*;
#(
  parameter int PTW   = 16,
  parameter int MTW   = 0,
  parameter int LEVEL = 8,
  parameter int CAP   = bmw_cap(LEVEL),
  parameter int QD    = 4,
  parameter int GAP   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
`ifdef BMW_SCHED_STATS_EN
  input  logic                       i_stat_clr,
  output logic [31:0]                o_stat_push,
  output logic [31:0]                o_stat_pop,
  output logic [31:0]                o_stat_empty_pop,
`endif
  input  logic                       i_push_valid,
  input  logic [MTW+PTW-1:0]         i_push_data,
  output logic                       o_push_ready,
  input  logic                       i_pop_valid,
  output logic                       o_pop_ready,
  output logic                       o_rsp_valid,
  output logic [MTW+PTW-1:0]         o_rsp_data,
  output logic                       o_rsp_empty,
  output logic                       o_rpu_push,
  output logic [MTW+PTW-1:0]         o_rpu_push_data,
  input  logic                       i_rpu_push_ready,
  output logic                       o_rpu_pop,
  input  logic                       i_rpu_pop_ready,
  input  logic                       i_rpu_pop_valid,
  input  logic [MTW+PTW-1:0]         i_rpu_pop_data,
  output logic [$clog2(CAP+1)-1:0]   o_count,
  output logic                       o_full
);

  localparam int DW = MTW + PTW;
  localparam int CW = $clog2(CAP + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  sched_state_t  state_q, state_d;
  logic          rr_q, rr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_empty_q, rsp_empty_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic          fifo_full_s, fifo_empty_s;
  logic [DW-1:0] fifo_head_s;
  logic          push_req_s, pop_req_s;
  logic          push_grant_s, pop_grant_s, empty_rply_s;

  bmw_sched_fifo #(.W(DW), .QD(QD)) u_fifo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_wr     (i_push_valid & ~fifo_full_s),
    .i_wdata  (i_push_data),
    .i_rd     (push_grant_s),
    .o_rdata  (fifo_head_s),
    .o_full   (fifo_full_s),
    .o_empty  (fifo_empty_s)
  );

  // Arbitration, FSM next state, occupancy and response formation.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    push_grant_s = 1'b0;
    pop_grant_s  = 1'b0;
    empty_rply_s = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_empty_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    push_req_s   = ~fifo_empty_s & ~full_q & i_rpu_push_ready;
    pop_req_s    = i_pop_valid & i_rpu_pop_ready & (count_q != '0);
    case (state_q)
      ST_IDLE: begin
        empty_rply_s = i_pop_valid & (count_q == '0) & fifo_empty_s;
        // On the pop's turn a gap-blocked pop still holds pushes back, so a push stream cannot starve pops.
        if (pop_req_s && (!rr_q || !push_req_s)) begin
          pop_grant_s = (gap_q == '0);
        end else begin
          push_grant_s = push_req_s;
        end
        if (pop_grant_s) begin
          state_d = ST_POP;
          rr_d    = 1'b1;
        end else if (push_grant_s) begin
          rr_d = 1'b0;
        end else begin
          rr_d = rr_q;
        end
        if (empty_rply_s) begin
          rsp_valid_d = 1'b1;
          rsp_empty_d = 1'b1;
          rsp_data_d  = EMPTY_ELEM[DW-1:0];
        end else begin
          rsp_data_d = rsp_data_q;
        end
      end
      ST_POP: begin
        if (i_rpu_pop_valid) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = i_rpu_pop_data;
        end else begin
          state_d = ST_POP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_grant_s) begin
      count_d = count_q + CW'(32'd1);
    end else if (pop_grant_s) begin
      count_d = count_q - CW'(32'd1);
    end else begin
      count_d = count_q;
    end
    full_d = (count_d == CW'(CAP));

    if (push_grant_s) begin
      gap_d = GW'(GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(32'd1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      gap_q       <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_empty_q <= 1'b0;
      rsp_data_q  <= EMPTY_ELEM[DW-1:0];
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      full_q      <= full_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_empty_q <= rsp_empty_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_push_ready    = ~fifo_full_s;
  assign o_pop_ready     = pop_grant_s | empty_rply_s;
  assign o_rpu_push      = push_grant_s;
  assign o_rpu_push_data = push_grant_s ? fifo_head_s : '0;
  assign o_rpu_pop       = pop_grant_s;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_empty     = rsp_empty_q;
  assign o_rsp_data      = rsp_data_q;
  assign o_count         = count_q;
  assign o_full          = full_q;

`ifdef BMW_SCHED_STATS_EN
  logic [31:0] stat_push_q, stat_push_d;
  logic [31:0] stat_pop_q, stat_pop_d;
  logic [31:0] stat_empty_q, stat_empty_d;

  // Free-running event counters; clear wins over a same-cycle event.
  always_comb begin
    if (i_stat_clr) begin
      stat_push_d  = '0;
      stat_pop_d   = '0;
      stat_empty_d = '0;
    end else begin
      stat_push_d  = stat_push_q + {31'd0, push_grant_s};
      stat_pop_d   = stat_pop_q + {31'd0, pop_grant_s};
      stat_empty_d = stat_empty_q + {31'd0, empty_rply_s};
    end
  end

  // Statistics registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      stat_push_q  <= '0;
      stat_pop_q   <= '0;
      stat_empty_q <= '0;
    end else begin
      stat_push_q  <= stat_push_d;
      stat_pop_q   <= stat_pop_d;
      stat_empty_q <= stat_empty_d;
    end
  end

  assign o_stat_push      = stat_push_q;
  assign o_stat_pop       = stat_pop_q;
  assign o_stat_empty_pop = stat_empty_q;
`endif

  bmw_sched_chk #(.CW(CW), .CAP(CAP)) u_chk (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_count    (count_q),
    .i_rpu_push (push_grant_s),
    .i_rpu_pop  (pop_grant_s)
  );

endmodule

// File: tb/tb_bmw_op_scheduler.sv
// Directed bench for bmw_op_scheduler with a 1-level tree (capacity 4) and a scripted pop RPU.
module tb_bmw_op_scheduler;

  logic        i_clk            = 1'b0;
  logic        i_arst_n         = 1'b0;
  logic        i_push_valid     = 1'b0;
  logic [15:0] i_push_data      = 16'h0000;
  logic        i_pop_valid      = 1'b0;
  logic        i_rpu_push_ready = 1'b1;
  logic        i_rpu_pop_ready  = 1'b1;
  logic        i_rpu_pop_valid  = 1'b0;
  logic [15:0] i_rpu_pop_data   = 16'h0000;
  logic        o_push_ready, o_pop_ready, o_rsp_valid, o_rsp_empty;
  logic        o_rpu_push, o_rpu_pop, o_full;
  logic [15:0] o_rsp_data, o_rpu_push_data;
  logic [2:0]  o_count;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          push_cyc = 0;
  int          pop_cyc  = 0;
  int          rsp_seen = 0;
  int          both_cnt = 0;
  int          base     = 0;
  int          npop     = 0;
  bit          got      = 1'b0;
  bit          rpu_auto = 1'b1;
  logic [15:0] rpu_ret  = 16'h0000;
  logic [15:0] push_log [$];
  bit          grant_log [$];

  bmw_op_scheduler #(.PTW(16), .MTW(0), .LEVEL(1), .QD(4), .GAP(1)) dut (
    .i_clk            (i_clk),
    .i_arst_n         (i_arst_n),
    .i_push_valid     (i_push_valid),
    .i_push_data      (i_push_data),
    .o_push_ready     (o_push_ready),
    .i_pop_valid      (i_pop_valid),
    .o_pop_ready      (o_pop_ready),
    .o_rsp_valid      (o_rsp_valid),
    .o_rsp_data       (o_rsp_data),
    .o_rsp_empty      (o_rsp_empty),
    .o_rpu_push       (o_rpu_push),
    .o_rpu_push_data  (o_rpu_push_data),
    .i_rpu_push_ready (i_rpu_push_ready),
    .o_rpu_pop        (o_rpu_pop),
    .i_rpu_pop_ready  (i_rpu_pop_ready),
    .i_rpu_pop_valid  (i_rpu_pop_valid),
    .i_rpu_pop_data   (i_rpu_pop_data),
    .o_count          (o_count),
    .o_full           (o_full)
  );

  initial forever #5 i_clk = ~i_clk;
  initial forever begin @(posedge i_clk); cyc++; end

  // Command/response monitor, sampled on the falling edge.
  initial forever begin
    @(negedge i_clk);
    if (o_rpu_push) begin push_log.push_back(o_rpu_push_data); grant_log.push_back(1'b0); push_cyc = cyc; end
    if (o_rpu_pop) begin grant_log.push_back(1'b1); pop_cyc = cyc; end
    if (o_rpu_push && o_rpu_pop) both_cnt++;
    if (o_rsp_valid) rsp_seen++;
  end

  // Pop RPU model: answers one cycle after each pop command with rpu_ret.
  initial forever begin
    @(negedge i_clk);
    if (o_rpu_pop && rpu_auto) begin
      @(posedge i_clk); #1;
      i_rpu_pop_valid = 1'b1;
      i_rpu_pop_data  = rpu_ret;
      @(posedge i_clk); #1;
      i_rpu_pop_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int got_v, input int exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic push_one(input logic [15:0] v);
    bit ok;
    ok = 1'b0;
    i_push_valid = 1'b1;
    i_push_data  = v;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_clk);
      if (o_push_ready) ok = 1'b1;
    end
    check_eq("push_accept", int'(ok), 1);
    step();
    i_push_valid = 1'b0;
  endtask

  task automatic do_pop(input string tag, input int exp_d, input int exp_e);
    bit ok;
    ok = 1'b0;
    i_pop_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_clk);
      if (o_pop_ready) ok = 1'b1;
    end
    check_eq({tag, "_ready"}, int'(ok), 1);
    step();
    i_pop_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge i_clk);
      if (o_rsp_valid) ok = 1'b1;
    end
    check_eq({tag, "_rsp_valid"}, int'(ok), 1);
    check_eq({tag, "_rsp_data"}, int'(o_rsp_data), exp_d);
    check_eq({tag, "_rsp_empty"}, int'(o_rsp_empty), exp_e);
    step();
  endtask

  initial begin
    // T1: reset values, then a pop with nothing stored.
    repeat (2) @(negedge i_clk);
    check_eq("rst_push_ready", int'(o_push_ready), 1);
    check_eq("rst_pop_ready", int'(o_pop_ready), 0);
    check_eq("rst_rsp_valid", int'(o_rsp_valid), 0);
    check_eq("rst_rsp_empty", int'(o_rsp_empty), 0);
    check_eq("rst_rsp_data", int'(o_rsp_data), 'hFFFF);
    check_eq("rst_rpu_push", int'(o_rpu_push), 0);
    check_eq("rst_rpu_pop", int'(o_rpu_pop), 0);
    check_eq("rst_count", int'(o_count), 0);
    check_eq("rst_full", int'(o_full), 0);
    i_arst_n = 1'b1;
    step(); step();
    do_pop("t1_empty", 'hFFFF, 1);

    // T3: push 7, pop raised in the push-issue cycle.
    i_push_valid = 1'b1;
    i_push_data  = 16'h0007;
    step();
    i_push_valid = 1'b0;
    rpu_ret = 16'h0007;
    do_pop("t3", 7, 0);
    check_eq("t3_gap_ok", int'((pop_cyc - push_cyc) >= 2), 1);
    check_eq("t3_count", int'(o_count), 0);

    // T2: three back-to-back pushes issue in order.
    push_log.delete();
    push_one(16'd5); push_one(16'd3); push_one(16'd9);
    step(); step(); step();
    check_eq("t2_npush", push_log.size(), 3);
    check_eq("t2_push0", int'(push_log[0]), 5);
    check_eq("t2_push1", int'(push_log[1]), 3);
    check_eq("t2_push2", int'(push_log[2]), 9);
    check_eq("t2_count", int'(o_count), 3);

    // T4: pushes and pops both pending; grants must alternate, starting with pop.
    grant_log.delete();
    rpu_ret = 16'h0042;
    i_pop_valid  = 1'b1;
    i_push_valid = 1'b1;
    i_push_data  = 16'd11; step();
    i_push_data  = 16'd12; step();
    i_push_data  = 16'd13; step();
    i_push_valid = 1'b0;
    npop = 1;
    for (int i = 0; i < 60 && npop < 4; i++) begin
      @(negedge i_clk);
      if (o_rpu_pop) npop++;
    end
    check_eq("t4_pops_issued", npop, 4);
    step();
    i_pop_valid = 1'b0;
    repeat (5) step();
    check_eq("t4_ngrants", grant_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("t4_grant%0d", i), int'(grant_log[i]), (i % 2 == 0) ? 1 : 0);
    end
    check_eq("t4_both_cmds", both_cnt, 0);
    check_eq("t4_count", int'(o_count), 2);

    // T5: fill the tree to capacity; extra pushes wait in the FIFO.
    rpu_ret = 16'h00A1;
    do_pop("t5_drain0", 'h00A1, 0);
    do_pop("t5_drain1", 'h00A1, 0);
    check_eq("t5_count0", int'(o_count), 0);
    push_log.delete();
    for (int v = 21; v <= 26; v++) push_one(16'(v));
    repeat (3) step();
    check_eq("t5_nissued", push_log.size(), 4);
    check_eq("t5_first", int'(push_log[0]), 21);
    check_eq("t5_last", int'(push_log[3]), 24);
    check_eq("t5_count_full", int'(o_count), 4);
    check_eq("t5_full", int'(o_full), 1);
    rpu_ret = 16'd21;
    do_pop("t5_pop", 21, 0);
    step(); step();
    check_eq("t5_nissued2", push_log.size(), 5);
    check_eq("t5_held_push", int'(push_log[4]), 25);
    check_eq("t5_count_refill", int'(o_count), 4);
    check_eq("t5_full_again", int'(o_full), 1);

    // T6: reset while a pop is outstanding.
    rpu_auto = 1'b0;
    i_pop_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge i_clk);
      if (o_pop_ready) got = 1'b1;
    end
    check_eq("t6_pop_ready", int'(got), 1);
    step();
    i_pop_valid = 1'b0;
    base = rsp_seen;
    step();
    i_arst_n = 1'b0;
    @(negedge i_clk);
    check_eq("t6_rst_count", int'(o_count), 0);
    check_eq("t6_rst_full", int'(o_full), 0);
    check_eq("t6_rst_push_ready", int'(o_push_ready), 1);
    check_eq("t6_rst_rsp_valid", int'(o_rsp_valid), 0);
    step();
    i_arst_n = 1'b1;
    rpu_auto = 1'b1;
    repeat (3) step();
    check_eq("t6_no_rsp", rsp_seen - base, 0);
    check_eq("t6_push_ready", int'(o_push_ready), 1);
    do_pop("t6_empty", 'hFFFF, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
